// File: rtl/trng_arbiter.sv
// trng_arbiter: shares one TRNG among NUM_REQ consumers using round-robin
// arbitration. Each captured word goes to exactly one requester. A hung TRNG
// is reported with a per-requester err pulse after TIMEOUT_CYCLES.
// Optional repetition health check: define TRNG_ARB_HEALTH_EN.
module trng_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DATA_W         = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [DATA_W-1:0]          rnd_data,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       trng_request,
  input  logic [DATA_W-1:0]          trng_data,
  input  logic                       trng_ready
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BLANK,
    ST_WAIT,
    ST_DELIVER
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rr_nxt;
  logic [ID_W-1:0]     grant_nxt;
  logic [ID_W-1:0]     grant_adv;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]   rnd_nxt;
  logic [NUM_REQ-1:0]  done_nxt;
  logic [NUM_REQ-1:0]  err_nxt;
  logic                busy_nxt;
  logic                trng_req_nxt;

`ifdef TRNG_ARB_HEALTH_EN
  logic [DATA_W-1:0]   last_word;
  logic [DATA_W-1:0]   last_nxt;
  logic [1:0]          rep_cnt;
  logic [1:0]          rep_nxt;
  logic                retry;
  logic                retry_nxt;
`endif

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] cand;
    logic            found;
    int unsigned     idx;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(ptr) + i) % NUM_REQ;
      cand = ID_W'(idx);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Pointer value that moves past the current grant.
  assign grant_adv = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
  assign cnt_inc   = cnt + CNT_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    rnd_nxt   = rnd_data;
    done_nxt  = '0;
    err_nxt   = '0;
`ifdef TRNG_ARB_HEALTH_EN
    last_nxt  = last_word;
    rep_nxt   = rep_cnt;
    retry_nxt = retry;
`endif

    case (state)
      ST_IDLE: begin
        if (|req) begin
          grant_nxt = rr_pick(req, rr_ptr);
          state_nxt = ST_REQ;
`ifdef TRNG_ARB_HEALTH_EN
          rep_nxt   = '0;
          retry_nxt = 1'b0;
`endif
        end
      end

      ST_REQ: begin
`ifdef TRNG_ARB_HEALTH_EN
        // A health retry keeps counting toward the same timeout.
        if (!retry) begin
          cnt_nxt = '0;
        end
`else
        cnt_nxt = '0;
`endif
        state_nxt = ST_BLANK;
      end

      ST_BLANK: begin
        // trng_ready may still be high from the previous word.
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_nxt = cnt_inc;
        if (trng_ready) begin
`ifdef TRNG_ARB_HEALTH_EN
          if (trng_data == last_word) begin
            if (rep_cnt == 2'd2) begin
              err_nxt[grant_id] = 1'b1;
              rr_nxt            = grant_adv;
              state_nxt         = ST_IDLE;
            end else begin
              rep_nxt   = rep_cnt + 2'd1;
              retry_nxt = 1'b1;
              state_nxt = ST_REQ;
            end
          end else
`endif
          begin
            state_nxt = ST_DELIVER;
            if (req[grant_id]) begin
              done_nxt[grant_id] = 1'b1;
              rnd_nxt            = trng_data;
`ifdef TRNG_ARB_HEALTH_EN
              last_nxt           = trng_data;
`endif
            end
          end
        end else if (cnt_inc >= CNT_LIMIT) begin
          err_nxt[grant_id] = 1'b1;
          rr_nxt            = grant_adv;
          state_nxt         = ST_IDLE;
        end
      end

      ST_DELIVER: begin
        rr_nxt    = grant_adv;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    trng_req_nxt = (state_nxt == ST_REQ);
    busy_nxt     = (state_nxt != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      cnt          <= '0;
      rnd_data     <= '0;
      done         <= '0;
      err          <= '0;
      busy         <= 1'b0;
      trng_request <= 1'b0;
`ifdef TRNG_ARB_HEALTH_EN
      last_word    <= '0;
      rep_cnt      <= '0;
      retry        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_nxt;
      grant_id     <= grant_nxt;
      cnt          <= cnt_nxt;
      rnd_data     <= rnd_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
      busy         <= busy_nxt;
      trng_request <= trng_req_nxt;
`ifdef TRNG_ARB_HEALTH_EN
      last_word    <= last_nxt;
      rep_cnt      <= rep_nxt;
      retry        <= retry_nxt;
`endif
    end
  end

endmodule
